// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Clocked stimulus-and-check stage for a two-input gate model. On start it
//   walks X/Y through the four input combinations (index = {Y,X}), holds each
//   vector for SETTLE_CYCLES cycles, samples Z on the last held cycle, and
//   compares the sample against EXPECT_TT. It reports a pass flag, a per-vector
//   error mask and a mismatch count.
//
//   Parameters
//     SETTLE_CYCLES  cycles each vector is held before Z is sampled (1..15)
//     EXPECT_TT      expected Z per vector index, bit i = vector i (default OR)
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     start      in   sweep request, only looked at while idle
//     Z          in   output of the gate under test
//     X, Y       out  registered gate inputs
//     busy       out  sweep in progress
//     done       out  one-cycle pulse when a sweep completes
//     pass       out  last completed sweep had no mismatch
//     err_mask   out  bit i set when vector i mismatched
//     err_count  out  number of mismatches (0..4)
//
//   Build option
//     GATE_SWEEP_ABORT_EN  when defined, the first mismatch ends the sweep.
//
//   state    | meaning
//   ST_IDLE  | X=Y=0, waiting for start; results of last sweep held
//   ST_RUN   | holding vector idx, settle counter cnt counting to the sample

module gate_sweep_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXPECT_TT     = 4'b1110
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       Z,
   output logic       X,
   output logic       Y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_mask,
   output logic [2:0] err_count
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       x_nxt, y_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [3:0] mask_nxt;
   logic [2:0] count_nxt;

   logic       mismatch;
   logic [3:0] mask_upd;
   logic [2:0] count_upd;
   logic       finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= 2'd0;
         cnt       <= 4'd0;
         X         <= 1'b0;
         Y         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_mask  <= 4'b0000;
         err_count <= 3'd0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         X         <= x_nxt;
         Y         <= y_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         err_mask  <= mask_nxt;
         err_count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      x_nxt     = X;
      y_nxt     = Y;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      pass_nxt  = pass;
      mask_nxt  = err_mask;
      count_nxt = err_count;
      finish    = 1'b0;

      // Case inequality so an unknown Z is scored as a mismatch in simulation.
      mismatch       = (Z !== EXPECT_TT[idx]);
      mask_upd       = err_mask;
      mask_upd[idx]  = err_mask[idx] | mismatch;
      count_upd      = err_count + {2'b00, mismatch};

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
               idx_nxt   = 2'd0;
               cnt_nxt   = 4'd0;
               x_nxt     = 1'b0;
               y_nxt     = 1'b0;
               busy_nxt  = 1'b1;
               pass_nxt  = 1'b0;
               mask_nxt  = 4'b0000;
               count_nxt = 3'd0;
            end
         end
         ST_RUN: begin
            if (cnt != CNT_LAST) begin
               cnt_nxt = cnt + 4'd1;
            end else begin
               mask_nxt  = mask_upd;
               count_nxt = count_upd;
`ifdef GATE_SWEEP_ABORT_EN
               finish = (idx == 2'd3) || mismatch;
`else
               finish = (idx == 2'd3);
`endif
               if (finish) begin
                  state_nxt = ST_IDLE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = (mask_upd == 4'b0000);
                  x_nxt     = 1'b0;
                  y_nxt     = 1'b0;
               end else begin
                  // Next vector goes out on the same edge as the sample.
                  idx_nxt = idx + 2'd1;
                  cnt_nxt = 4'd0;
                  x_nxt   = idx_nxt[0];
                  y_nxt   = idx_nxt[1];
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

   localparam int unsigned S      = 2;
   localparam logic [3:0]  EXP_TT = 4'b1110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] gate_tt = 4'b1110;
   logic       z;
   logic       x, y, busy, done, pass;
   logic [3:0] err_mask;
   logic [2:0] err_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Behavioural gate under test: Z is a truth-table lookup on {Y,X}.
   assign z = gate_tt[{y, x}];

   gate_sweep_checker #(
      .SETTLE_CYCLES (S),
      .EXPECT_TT     (EXP_TT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .Z         (z),
      .X         (x),
      .Y         (y),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_mask  (err_mask),
      .err_count (err_count)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x"},     8'(x), 8'd0);
      chk({tag, "_y"},     8'(y), 8'd0);
      chk({tag, "_busy"},  8'(busy), 8'd0);
      chk({tag, "_done"},  8'(done), 8'd0);
      chk({tag, "_pass"},  8'(pass), 8'd0);
      chk({tag, "_mask"},  8'(err_mask), 8'd0);
      chk({tag, "_count"}, 8'(err_count), 8'd0);
   endtask

   // One full sweep with gate truth table tt. Expected results come from the
   // bitwise difference between the gate and the expected table.
   task automatic sweep(input logic [3:0] tt, input bit repulse);
      logic [3:0] m;
      int         nbad;
      int         end_k;
      m     = tt ^ EXP_TT;
      end_k = 4 * int'(S);
`ifdef GATE_SWEEP_ABORT_EN
      begin
         int first;
         first = -1;
         for (int i = 0; i < 4; i++)
            if (m[i] && first < 0) first = i;
         if (first >= 0) begin
            m     = 4'(1 << first);
            end_k = (first + 1) * int'(S);
         end
      end
`endif
      nbad    = $countones(m);
      gate_tt = tt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < end_k; k++) begin
         chk("run_busy", 8'(busy), 8'd1);
         chk("run_done", 8'(done), 8'd0);
         chk("run_xy", {6'b0, y, x}, 8'(k / int'(S)));
         start = (repulse && k == 3) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      chk("end_done",  8'(done), 8'd1);
      chk("end_busy",  8'(busy), 8'd0);
      chk("end_pass",  8'(pass), 8'(nbad == 0));
      chk("end_mask",  8'(err_mask), 8'(m));
      chk("end_count", 8'(err_count), 8'(nbad));
      chk("end_xy",    {6'b0, y, x}, 8'd0);
      @(negedge clk);
      chk("post_done", 8'(done), 8'd0);
      chk("post_busy", 8'(busy), 8'd0);
      chk("hold_pass", 8'(pass), 8'(nbad == 0));
      chk("hold_mask", 8'(err_mask), 8'(m));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      sweep(4'b1110, 1'b0);   // correct OR gate
      sweep(4'b0000, 1'b0);   // Z stuck at 0
      sweep(4'b1000, 1'b0);   // AND gate
      sweep(4'b1110, 1'b1);   // start re-pulsed mid-sweep
      sweep(4'b1111, 1'b1);   // Z stuck at 1

      // Reset in the middle of a sweep.
      gate_tt = 4'b0000;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk) rst_n = 1'b1;
      sweep(4'b1110, 1'b0);

      for (int n = 0; n < 10; n++)
         sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus-and-check stage for two-input gate models such as the NAND-built OR gate. On `start`, it drives every input combination onto `X`/`Y`, waits a configurable settle time, and samples the gate's `Z` output. It compares each sample against an expected truth table and reports a pass/fail result with an error mask and count. It replaces the hand-written `#10`/`$display` stimulus with a self-checking, clocked block that sits upstream of the gate on `X`/`Y` and downstream of it on `Z`.

## Interface
- `SETTLE_CYCLES`, 2: cycles each vector is held before `Z` is sampled; legal range 1..15.
- `EXPECT_TT`, 4'b1110: expected `Z` per vector index; bit i is the expected value for vector i (default = OR).
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `Z`  in  1  output of the gate under test.
- `X`  out  1  gate input A, registered.
- `Y`  out  1  gate input B, registered.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  1 if the last completed sweep had no mismatch; held until the next accepted start.
- `err_mask`  out  4  bit i set if vector i mismatched.
- `err_count`  out  3  number of mismatches, 0..4.

## Operation
- Vector order is fixed: index i = {Y,X}, so 0:(X0,Y0), 1:(X1,Y0), 2:(X0,Y1), 3:(X1,Y1).
- States:
  - IDLE: `X`=`Y`=0, `busy`=0.
  - RUN: holds vector `idx`; a settle counter `cnt` runs 0..SETTLE_CYCLES-1.
- Transitions:
  - IDLE, `start`=1 → RUN with `idx`=0 and `cnt`=0. On the same edge, `err_mask`, `err_count` and `pass` are cleared.
  - RUN, `cnt`<SETTLE_CYCLES-1 → `cnt`+1.
  - RUN, `cnt`=SETTLE_CYCLES-1 → sample `Z` and compare with `EXPECT_TT[idx]`.
    - On mismatch: set `err_mask[idx]` and increment `err_count`.
    - If `idx`<3: `idx`+1, `cnt`=0, and `X`/`Y` are updated on the same edge.
    - If `idx`=3: go to IDLE, pulse `done`, set `pass` = (final mask == 0), and return `X`/`Y` to 0.
- Comparison uses case inequality, so in simulation an x/z value on `Z` counts as a mismatch.
- `start` in RUN is ignored; it is neither queued nor restarts the sweep.
- `err_count` saturates by construction (at most 4) and never wraps.

## Timing
- Reset values: `X`=0, `Y`=0, `busy`=0, `done`=0, `pass`=0, `err_mask`=0000, `err_count`=0, state IDLE.
- Reset mid-sweep forces reset values immediately and discards partial results.
- Let edge E0 accept `start`. Then:
  - Vector i is visible from E0+i·S to E0+(i+1)·S, where S = SETTLE_CYCLES.
  - `Z` for vector i is sampled at edge E0+(i+1)·S.
- `done`, final `pass` and final `err_mask`/`err_count` are valid in the cycle after E0+4·S. Start-to-done latency is 4·S cycles.
- `busy` is high from after E0 through E0+4·S, and low in the `done` cycle.
- Back-to-back: if `start`=1 during the `done` cycle, a new sweep is accepted at the next edge. Results stay readable through the `done` cycle.
- `Z` must be stable within S cycles of an `X`/`Y` change; the checker adds no synchronizer.

## Configuration
- Macro `GATE_SWEEP_ABORT_EN`.
- Defined: the first mismatch ends the sweep at that sample edge.
  - Next cycle: `done`=1, `pass`=0, `err_count`=1, `err_mask` has exactly that vector's bit set, and `X`/`Y` return to 0.
- Undefined: all 4 vectors are always run and all mismatches are accumulated.

## Test plan
- Correct OR gate, S=2: pulse `start` → `done` 8 cycles later, `pass`=1, `err_mask`=0000, `err_count`=0; `X`/`Y` sequence 00,10,01,11 with 2 cycles each.
- `Z` stuck at 0, abort undefined → `done` after 8 cycles, `pass`=0, `err_mask`=1110, `err_count`=3.
- AND gate on `Z` with default `EXPECT_TT` → `err_mask`=0110, `err_count`=2, `pass`=0.
- `GATE_SWEEP_ABORT_EN` defined, `Z` stuck at 0, S=2 → `done` 4 cycles after accept, `err_mask`=0010, `err_count`=1.
- `start` re-pulsed at cycle 3 of a sweep → exactly one `done`, still at cycle 8, with unchanged results.
- `rst_n` low at cycle 5 of a sweep → all outputs at reset values immediately; a following `start` gives a clean 8-cycle pass.
